// File: rtl/lms_weight_update_pkg.sv
// Shared definitions for the LMS weight updater and the FIR that consumes its weights:
// the update FSM state encoding and a wide saturating clamp.
package lms_weight_update_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPDATE = 2'd1,
      DONE   = 2'd2
   } lms_state_t;

   // Width of the intermediate accumulator used before clamping; comfortably wider
   // than a full product plus a weight for any DATA_WIDTH up to 31.
   localparam int ACC_WIDTH = 64;

   // Clamp a wide signed value to the range of a signed 'width'-bit word.
   function automatic logic signed [ACC_WIDTH-1:0] saturate(
      input logic signed [ACC_WIDTH-1:0] value,
      input int unsigned                 width
   );
      logic signed [ACC_WIDTH-1:0] max_val;
      logic signed [ACC_WIDTH-1:0] min_val;
      max_val = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_val = -max_val - 64'sd1;
      if (value > max_val) begin
         return max_val;
      end else if (value < min_val) begin
         return min_val;
      end else begin
         return value;
      end
   endfunction

endpackage

// File: rtl/lms_tap_mac.sv
// One LMS tap step: w_new = sat(w + floor(err * x / 2^(DATA_WIDTH-1+MU_SHIFT))).
// Purely combinational; the caller time-multiplexes it across taps.
module lms_tap_mac
   import lms_weight_update_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int MU_SHIFT   = 4
) (
   input  logic signed [DATA_WIDTH-1:0] err_q,
   input  logic signed [DATA_WIDTH-1:0] sample,
   input  logic signed [DATA_WIDTH-1:0] weight,
   output logic signed [DATA_WIDTH-1:0] weight_new
);

   localparam int PW    = 2 * DATA_WIDTH;
   localparam int SHIFT = DATA_WIDTH - 1 + MU_SHIFT;

   logic signed [PW-1:0]        err_ext;
   logic signed [PW-1:0]        sample_ext;
   logic signed [PW-1:0]        product;
   logic signed [PW-1:0]        scaled;
   logic signed [ACC_WIDTH-1:0] sum;

   // Operands are sign-extended to the full product width so the multiply is exact.
   assign err_ext    = {{DATA_WIDTH{err_q[DATA_WIDTH-1]}}, err_q};
   assign sample_ext = {{DATA_WIDTH{sample[DATA_WIDTH-1]}}, sample};
   assign product    = err_ext * sample_ext;

   // Arithmetic shift gives floor rounding toward minus infinity.
   assign scaled = product >>> SHIFT;

   // Sum is formed wide so overflow is visible to the clamp rather than wrapping.
   assign sum = {{(ACC_WIDTH-PW){scaled[PW-1]}}, scaled}
              + {{(ACC_WIDTH-DATA_WIDTH){weight[DATA_WIDTH-1]}}, weight};

   assign weight_new = DATA_WIDTH'(saturate(sum, DATA_WIDTH));

endmodule

// File: rtl/lms_weight_update.sv
// LMS coefficient updater: keeps a regressor delay line, and on each accepted error
// walks all taps through a single shared MAC into a working copy, then publishes the
// complete new coefficient set in one cycle so the FIR never sees a partial update.
module lms_weight_update
   import lms_weight_update_pkg::*;
#(
   parameter int N          = 10,
   parameter int DATA_WIDTH = 16,
   parameter int MU_SHIFT   = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic signed [DATA_WIDTH-1:0] x_in,
   input  logic signed [DATA_WIDTH-1:0] err,
   input  logic                         err_valid,
   output logic signed [DATA_WIDTH-1:0] weights [N],
   output logic                         busy,
   output logic                         done
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   lms_state_t                   state;
   lms_state_t                   state_next;
   logic [CW-1:0]                tap_cnt;
   logic                         last_tap;
   logic                         load;
   logic                         step;
   logic                         commit;

   logic signed [DATA_WIDTH-1:0] x_line [N];
   logic signed [DATA_WIDTH-1:0] r      [N];
   logic signed [DATA_WIDTH-1:0] wk     [N];
   logic signed [DATA_WIDTH-1:0] err_q;
   logic signed [DATA_WIDTH-1:0] r_sel;
   logic signed [DATA_WIDTH-1:0] wk_sel;
   logic signed [DATA_WIDTH-1:0] wk_new;

   assign last_tap = (tap_cnt == CW'(N - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: accept in IDLE, walk taps in UPDATE, publish in DONE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (err_valid) state_next = UPDATE;
         UPDATE:  if (last_tap)  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Control decode from the current state.
   always_comb begin
      busy   = 1'b0;
      load   = 1'b0;
      step   = 1'b0;
      commit = 1'b0;
      case (state)
         IDLE:    load   = err_valid;
         UPDATE:  begin busy = 1'b1; step = 1'b1; end
         DONE:    begin busy = 1'b1; commit = 1'b1; end
         default: ;
      endcase
   end

   // Select the operands of the tap currently being processed.
   always_comb begin
      r_sel  = '0;
      wk_sel = '0;
      for (int k = 0; k < N; k++) begin
         if (tap_cnt == CW'(k)) begin
            r_sel  = r[k];
            wk_sel = wk[k];
         end
      end
   end

   lms_tap_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .MU_SHIFT   (MU_SHIFT)
   ) u_mac (
      .err_q      (err_q),
      .sample     (r_sel),
      .weight     (wk_sel),
      .weight_new (wk_new)
   );

   // Regressor delay line shifts on every sample strobe regardless of update activity.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) x_line[k] <= '0;
      end else if (en) begin
         x_line[0] <= x_in;
         for (int k = 1; k < N; k++) x_line[k] <= x_line[k-1];
      end
   end

   // Update datapath: snapshot on accept (pre-shift line), then one tap per cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) begin
            r[k]  <= '0;
            wk[k] <= '0;
         end
         err_q   <= '0;
         tap_cnt <= '0;
      end else if (load) begin
         for (int k = 0; k < N; k++) begin
            r[k]  <= x_line[k];
            wk[k] <= weights[k];
         end
         err_q   <= err;
         tap_cnt <= '0;
      end else if (step) begin
         for (int k = 0; k < N; k++) begin
            if (tap_cnt == CW'(k)) wk[k] <= wk_new;
         end
         tap_cnt <= tap_cnt + 1'b1;
      end
   end

   // Publish the whole working set at once and flag it with a one-cycle done.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) weights[k] <= '0;
         done <= 1'b0;
      end else begin
         done <= commit;
         if (commit) begin
            for (int k = 0; k < N; k++) weights[k] <= wk[k];
         end
      end
   end

endmodule
